// File: rtl/usb_wire_direction_ctrl.sv
// Half-duplex owner arbitration for the USB D+/D- wire: turnaround guard before TX,
// quiet gaps after TX/RX, and conversion of the reader's idle timeout into a response timeout.
module usb_wire_direction_ctrl #(
    parameter int unsigned TURN_FS = 8,
    parameter int unsigned TURN_LS = 64,
    parameter int unsigned GAP_FS  = 8,
    parameter int unsigned GAP_LS  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fullSpeedRate,
    input  logic       txReq,
    input  logic       txDone,
    input  logic       expectResp,
    input  logic       abort,
    input  logic       RxWireActive,
    input  logic       noActivityTimeOut,
    output logic       txGnt,
    output logic       TxWireActiveDrive,
    output logic       noActivityTimeOutEnable,
    output logic       respTimeOut,
    output logic       rxBusy,
    output logic [2:0] wireState
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ST_W  = 3;

    localparam logic [ST_W-1:0] IDLE      = 3'd0;
    localparam logic [ST_W-1:0] TX_TURN   = 3'd1;
    localparam logic [ST_W-1:0] TX_ACTIVE = 3'd2;
    localparam logic [ST_W-1:0] WAIT_RESP = 3'd3;
    localparam logic [ST_W-1:0] RX_ACTIVE = 3'd4;
    localparam logic [ST_W-1:0] GAP       = 3'd5;

    logic [ST_W-1:0]  state;
    logic [ST_W-1:0]  nextState;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nextCnt;
    logic [CNT_W-1:0] turnLoad;
    logic [CNT_W-1:0] gapLoad;
    logic             nextRespTimeOut;
    logic             nextTxGnt;
    logic             nextDrive;
    logic             nextToEnable;
    logic             nextRxBusy;

    // State, counter and Moore outputs, all registered together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                   <= IDLE;
            cnt                     <= '0;
            txGnt                   <= 1'b0;
            TxWireActiveDrive       <= 1'b0;
            noActivityTimeOutEnable <= 1'b0;
            respTimeOut             <= 1'b0;
            rxBusy                  <= 1'b0;
            wireState               <= IDLE;
        end else begin
            state                   <= nextState;
            cnt                     <= nextCnt;
            txGnt                   <= nextTxGnt;
            TxWireActiveDrive       <= nextDrive;
            noActivityTimeOutEnable <= nextToEnable;
            respTimeOut             <= nextRespTimeOut;
            rxBusy                  <= nextRxBusy;
            wireState               <= nextState;
        end
    end

    // Next-state and dwell counter; abort and illegal encodings fall back to the IDLE defaults
    always_comb begin
        nextState       = IDLE;
        nextCnt         = '0;
        nextRespTimeOut = 1'b0;
        turnLoad        = fullSpeedRate ? CNT_W'(TURN_FS - 1) : CNT_W'(TURN_LS - 1);
        gapLoad         = fullSpeedRate ? CNT_W'(GAP_FS - 1)  : CNT_W'(GAP_LS - 1);
        if (!abort) begin
            case (state)
                IDLE: begin
                    if (RxWireActive) begin
                        nextState = RX_ACTIVE;
                    end else if (txReq) begin
                        nextState = TX_TURN;
                        nextCnt   = turnLoad;
                    end
                end
                TX_TURN: begin
                    if (RxWireActive) begin
                        nextState = RX_ACTIVE;
                    end else if (!txReq) begin
                        nextState = IDLE;
                    end else if (cnt == '0) begin
                        nextState = TX_ACTIVE;
                    end else begin
                        nextState = TX_TURN;
                        nextCnt   = cnt - CNT_W'(1);
                    end
                end
                TX_ACTIVE: begin
                    if (txDone && expectResp) begin
                        nextState = WAIT_RESP;
                    end else if (txDone) begin
                        nextState = GAP;
                        nextCnt   = gapLoad;
                    end else begin
                        nextState = TX_ACTIVE;
                    end
                end
                WAIT_RESP: begin
                    if (RxWireActive) begin
                        nextState = RX_ACTIVE;
                    end else if (noActivityTimeOut) begin
                        nextState       = IDLE;
                        nextRespTimeOut = 1'b1;
                    end else begin
                        nextState = WAIT_RESP;
                    end
                end
                RX_ACTIVE: begin
                    if (!RxWireActive) begin
                        nextState = GAP;
                        nextCnt   = gapLoad;
                    end else begin
                        nextState = RX_ACTIVE;
                    end
                end
                GAP: begin
                    if (RxWireActive) begin
                        nextState = RX_ACTIVE;
                    end else if (cnt != '0) begin
                        nextState = GAP;
                        nextCnt   = cnt - CNT_W'(1);
                    end
                end
                default: nextState = IDLE;
            endcase
        end
    end

    // Output decode from the state being entered
    always_comb begin
        nextTxGnt    = (nextState == TX_ACTIVE);
        nextDrive    = (nextState == TX_ACTIVE);
        nextToEnable = (nextState == WAIT_RESP);
        nextRxBusy   = (nextState == RX_ACTIVE);
    end

endmodule

// File: tb/tb_usb_wire_direction_ctrl.sv
// Scoreboarded bench for usb_wire_direction_ctrl: directed scenarios plus random traffic
// compared each cycle against a phase/dwell reference model.
module tb_usb_wire_direction_ctrl;

    localparam int unsigned TURN_FS = 8;
    localparam int unsigned TURN_LS = 64;
    localparam int unsigned GAP_FS  = 8;
    localparam int unsigned GAP_LS  = 64;

    typedef struct packed {
        logic       txGnt;
        logic       drive;
        logic       toEnable;
        logic       respTo;
        logic       rxBusy;
        logic [2:0] st;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fullSpeedRate = 1'b1;
    logic       txReq = 1'b0;
    logic       txDone = 1'b0;
    logic       expectResp = 1'b0;
    logic       abort = 1'b0;
    logic       RxWireActive = 1'b0;
    logic       noActivityTimeOut = 1'b0;
    logic       txGnt;
    logic       TxWireActiveDrive;
    logic       noActivityTimeOutEnable;
    logic       respTimeOut;
    logic       rxBusy;
    logic [2:0] wireState;

    int   errors = 0;
    int   checks = 0;
    obs_t expQ[$];

    // Reference model: which phase the wire is in, and how many cycles of dwell remain
    int   mPhase = 0;
    int   mLeft  = 0;

    usb_wire_direction_ctrl #(
        .TURN_FS(TURN_FS), .TURN_LS(TURN_LS), .GAP_FS(GAP_FS), .GAP_LS(GAP_LS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fullSpeedRate(fullSpeedRate),
        .txReq(txReq),
        .txDone(txDone),
        .expectResp(expectResp),
        .abort(abort),
        .RxWireActive(RxWireActive),
        .noActivityTimeOut(noActivityTimeOut),
        .txGnt(txGnt),
        .TxWireActiveDrive(TxWireActiveDrive),
        .noActivityTimeOutEnable(noActivityTimeOutEnable),
        .respTimeOut(respTimeOut),
        .rxBusy(rxBusy),
        .wireState(wireState)
    );

    always #5 clk = ~clk;

    function automatic obs_t observe();
        obs_t o;
        o.txGnt    = txGnt;
        o.drive    = TxWireActiveDrive;
        o.toEnable = noActivityTimeOutEnable;
        o.respTo   = respTimeOut;
        o.rxBusy   = rxBusy;
        o.st       = wireState;
        return o;
    endfunction

    // Effect of one clock edge with the given inputs, expressed as wire ownership phases
    function automatic obs_t modelStep(input logic req, input logic rx, input logic done,
                                       input logic expR, input logic ab, input logic noAct,
                                       input logic fs);
        obs_t o;
        int   nxt;
        bit   pulse;
        nxt   = mPhase;
        pulse = 1'b0;
        if (ab) begin
            nxt = 0;
        end else begin
            case (mPhase)
                0: if (rx) nxt = 4;
                   else if (req) begin nxt = 1; mLeft = fs ? TURN_FS : TURN_LS; end
                1: if (rx) nxt = 4;
                   else if (!req) nxt = 0;
                   else begin mLeft = mLeft - 1; if (mLeft == 0) nxt = 2; end
                2: if (done) begin
                       nxt = expR ? 3 : 5;
                       if (!expR) mLeft = fs ? GAP_FS : GAP_LS;
                   end
                3: if (rx) nxt = 4;
                   else if (noAct) begin nxt = 0; pulse = 1'b1; end
                4: if (!rx) begin nxt = 5; mLeft = fs ? GAP_FS : GAP_LS; end
                5: if (rx) nxt = 4;
                   else begin mLeft = mLeft - 1; if (mLeft == 0) nxt = 0; end
                default: nxt = 0;
            endcase
        end
        mPhase     = nxt;
        o.txGnt    = (nxt == 2);
        o.drive    = (nxt == 2);
        o.toEnable = (nxt == 3);
        o.respTo   = pulse;
        o.rxBusy   = (nxt == 4);
        o.st       = 3'(nxt);
        return o;
    endfunction

    // Called at a falling edge: drive inputs for the next rising edge, queue the expected result
    task automatic cyc(input logic req, input logic rx, input logic done = 1'b0,
                       input logic expR = 1'b0, input logic ab = 1'b0, input logic noAct = 1'b0);
        txReq             = req;
        RxWireActive      = rx;
        txDone            = done;
        expectResp        = expR;
        abort             = ab;
        noActivityTimeOut = noAct;
        expQ.push_back(modelStep(req, rx, done, expR, ab, noAct, fullSpeedRate));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    task automatic directCheck(input string name, input obs_t req);
        obs_t act;
        act = observe();
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
        end
    endtask

    // Monitor: compares the DUT against the queued expectation after every rising edge
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                a = observe();
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle t=%0t actual=%b required=%b (gnt,drv,toEn,rto,rxb,st)",
                             $time, a, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic rxLvl;
        logic reqLvl;
        #3;
        directCheck("reset", '0);
        @(negedge clk);
        rst = 1'b1;

        // Full-speed grant, transmit without response, gap
        fullSpeedRate = 1'b1;
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        idle(10);

        // Low-speed transmit expecting a response that never comes
        fullSpeedRate = 1'b0;
        for (int i = 0; i < 66; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        idle(4);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Response arrives together with the timeout: receive wins
        fullSpeedRate = 1'b1;
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
        idle(10);

        // Receive interrupts turnaround; held request is granted only after gap and a fresh turn
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        idle(10);

        // Abort in TX_ACTIVE, then in WAIT_RESP alongside a timeout
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Asynchronous reset mid-gap
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        #2 rst = 1'b0;
        #1 directCheck("async_reset", '0);
        @(negedge clk);
        rst    = 1'b1;
        mPhase = 0;
        mLeft  = 0;

        // Simultaneous request and receive from IDLE; request withdrawn mid-turn
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        idle(10);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        idle(3);

        // Rate change mid-count applies only at the next load
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        fullSpeedRate = 1'b0;
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        idle(66);
        fullSpeedRate = 1'b1;

        // Random traffic
        rxLvl  = 1'b0;
        reqLvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) rxLvl = ~rxLvl;
            if ($urandom_range(0, 7) == 0) reqLvl = ~reqLvl;
            if ($urandom_range(0, 199) == 0) fullSpeedRate = ~fullSpeedRate;
            cyc(reqLvl, rxLvl, $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 80) == 0, $urandom_range(0, 8) == 0);
        end
        idle(2);

        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
